// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline definitions for the memory-access stage: funct3 size codes, FSM state, MEM/WB record.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_access_stage_pkg;

  // Load/store size encodings carried in funct3
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2
  } mem_state_e;

  // Everything the WB stage sees, registered as one record
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memtoreg;
    logic        jal;
    logic        jalr;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        misalign;
    logic        buserr;
  } memwb_t;

  // Halfwords need bit0 clear, words (and unused size codes) need both low bits clear
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return off[0];
      default: return |off;
    endcase
  endfunction

  // Byte enables for the lanes touched by an access of this size at this offset
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store data across lanes so the memory picks it up under any byte enable
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load aligner: shifts the addressed byte/half down to bit 0 and sign- or zero-extends it.
// Latency: combinational.
// Backpressure: none.
module load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  // Pick width and extension from the load size code
  always_comb begin
    data_o = shifted;
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data_o = {24'd0, shifted[7:0]};
      F3_HU:   data_o = {16'd0, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory requests, aligns load data and registers the MEM/WB record.
// Latency: 1 cycle for non-memory ops; memory ops complete on the edge after gnt (store) / rvalid (load).
// Backpressure: stall_out freezes upstream while an access is outstanding; abandoned after MAX_WAIT cycles.
module mem_access_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        Ctl_RegWrite_in,
  input  logic        Ctl_MemtoReg_in,
  input  logic        Ctl_MemRead_in,
  input  logic        Ctl_MemWrite_in,
  input  logic        jal_in,
  input  logic        jalr_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] ALUresult_in,
  input  logic [31:0] WriteData_in,
  input  logic [4:0]  Rd_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_gnt,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic        Ctl_RegWrite_out,
  output logic        Ctl_MemtoReg_out,
  output logic        jal_out,
  output logic        jalr_out,
  output logic [31:0] PC_out,
  output logic [31:0] ALUresult_out,
  output logic [31:0] ReadData_out,
  output logic [4:0]  Rd_out,
  output logic        misalign_out,
  output logic        buserr_out
);
  import mem_access_stage_pkg::*;

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  mem_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  memwb_t        wb_q, wb_d;

  logic [1:0]  off;
  logic        is_mem, is_load, is_store, misaligned, mem_go, misal_now;
  logic        stall_raw, req_raw, timeout, done, capture;
  logic [31:0] load_data;

  assign off        = ALUresult_in[1:0];
  assign is_mem     = in_valid & (Ctl_MemRead_in | Ctl_MemWrite_in);
  assign is_load    = Ctl_MemRead_in;
  assign is_store   = Ctl_MemWrite_in & ~Ctl_MemRead_in;
  assign misaligned = is_misaligned(funct3_in, off);
  assign mem_go     = is_mem & ~misaligned;
  assign misal_now  = (state_q == ST_IDLE) & is_mem & misaligned;

  load_align u_load_align (
    .rdata_i  (dmem_rdata),
    .offset_i (off),
    .funct3_i (funct3_in),
    .data_o   (load_data)
  );

  // Request bus comes straight from the frozen EX/MEM register, so it stays stable until gnt
  assign dmem_req   = req_raw;
  assign dmem_we    = req_raw & is_store;
  assign dmem_be    = req_raw ? store_be(funct3_in, off) : 4'b0000;
  assign dmem_addr  = {ALUresult_in[31:2], 2'b00};
  assign dmem_wdata = store_wdata(funct3_in, WriteData_in);

  // Reset must release the pipeline even while a memory op sits on the inputs
  assign stall_out = stall_raw & rst_n;

  // FSM state and wait counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, request/stall generation and timeout detection; timeout overrides any response
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    req_raw   = 1'b0;
    timeout   = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_go) begin
          state_d   = ST_REQ;
          cnt_d     = '0;
          stall_raw = 1'b1;
        end
      end
      ST_REQ: begin
        if (cnt_q == CNT_MAX) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          req_raw   = 1'b1;
          stall_raw = 1'b1;
          cnt_d     = cnt_q + CW'(1);
          if (dmem_gnt) begin
            if (!is_load || dmem_rvalid) begin
              done      = 1'b1;
              stall_raw = 1'b0;
              state_d   = ST_IDLE;
              cnt_d     = '0;
            end else begin
              state_d = ST_WAIT_RSP;
            end
          end
        end
      end
      ST_WAIT_RSP: begin
        if (cnt_q == CNT_MAX) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (dmem_rvalid) begin
          done    = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          stall_raw = 1'b1;
          cnt_d     = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // The instruction retires to WB when it needs no memory, is rejected as misaligned, completes or times out
  assign capture = ((state_q == ST_IDLE) & in_valid & ~mem_go) | done | timeout;

  // Build the MEM/WB record; anything not retiring this cycle becomes an all-zero bubble
  always_comb begin
    wb_d = '0;
    if (capture) begin
      wb_d.valid    = 1'b1;
      wb_d.regwrite = Ctl_RegWrite_in & ~misal_now & ~timeout;
      wb_d.memtoreg = Ctl_MemtoReg_in;
      wb_d.jal      = jal_in;
      wb_d.jalr     = jalr_in;
      wb_d.pc       = PC_in;
      wb_d.alu      = ALUresult_in;
      wb_d.rd       = Rd_in;
      wb_d.rdata    = (done & is_load) ? load_data : 32'd0;
      wb_d.misalign = misal_now;
      wb_d.buserr   = timeout;
    end
  end

  // MEM/WB pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign wb_valid         = wb_q.valid;
  assign Ctl_RegWrite_out = wb_q.regwrite;
  assign Ctl_MemtoReg_out = wb_q.memtoreg;
  assign jal_out          = wb_q.jal;
  assign jalr_out         = wb_q.jalr;
  assign PC_out           = wb_q.pc;
  assign ALUresult_out    = wb_q.alu;
  assign ReadData_out     = wb_q.rdata;
  assign Rd_out           = wb_q.rd;
  assign misalign_out     = wb_q.misalign;
  assign buserr_out       = wb_q.buserr;

endmodule
